hazard_fwd_unit: RTL and testbench

Parametrised hazard-detection and forwarding unit for the pipelined MIPS core. It tracks every in-flight register writer in a shift table that mirrors the post-decode pipeline stages. For each decode-stage source operand it produces a forwarding select and a load-use stall, generalising the fixed two-operand EX/MEM forwarding logic to N sources and D tracked stages. It also counts stalls and forwards for performance measurement.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_match.sv | 42 ++++
 rtl/hazard_fwd_unit.sv | 113 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard detection / forwarding unit.
package hazard_pkg;

    // Forward select value meaning "take the operand from the register file".
    localparam int unsigned FWD_RF = 0;

    // Table entries carry a destination field wide enough for any supported
    // REG_AW; narrower addresses are zero-extended on entry and on compare.
    localparam int unsigned REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic                  regwrite;
        logic                  memread;
        logic [REG_AW_MAX-1:0] dest;
    } entry_t;

    // Width of one forward select: 0 = register file, 1..depth = stage index + 1.
    function automatic int unsigned sel_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-first priority match of one source operand against the writer table.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SELW     = 2
) (
    input  entry_t [DEPTH-1:0] entries_i,
    input  logic [REG_AW-1:0]  src_addr_i,
    input  logic               src_used_i,
    output logic               hit_o,
    output logic               is_load_stall_o,
    output logic [SELW-1:0]    sel_o
);

    logic [REG_AW_MAX-1:0] src_ext;
    logic                  win_load;
    logic [SELW-1:0]       win_sel;

    assign src_ext = REG_AW_MAX'(src_addr_i);

    // Scan oldest to youngest so the youngest matching entry is the last one written.
    always_comb begin
        hit_o    = 1'b0;
        win_load = 1'b0;
        win_sel  = SELW'(FWD_RF);
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            if (src_used_i && (src_addr_i != '0) && entries_i[k].valid &&
                entries_i[k].regwrite && (entries_i[k].dest == src_ext)) begin
                hit_o    = 1'b1;
                // Load data not yet available at this stage: must stall, not forward.
                win_load = entries_i[k].memread && (k < int'(LOAD_LAT));
                win_sel  = SELW'(k + 1);
            end
        end
        is_load_stall_o = hit_o && win_load;
        sel_o           = win_load ? SELW'(FWD_RF) : win_sel;
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for N decode sources over D tracked stages,
// with saturating stall / forward performance counters.
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned NSRC        = 2,
    parameter int unsigned DEPTH       = 3,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue_valid,
    input  logic                            issue_regwrite,
    input  logic                            issue_memread,
    input  logic [REG_AW-1:0]               issue_dest,
    input  logic [NSRC*REG_AW-1:0]          src_addr,
    input  logic [NSRC-1:0]                 src_used,
    input  logic                            flush,
    input  logic                            cnt_clear,
    output logic                            stall,
    output logic [NSRC*sel_w(DEPTH)-1:0]    fwd_sel,
    output logic [CNT_W-1:0]                stall_cnt,
    output logic [CNT_W-1:0]                fwd_cnt
);

    localparam int unsigned SELW = sel_w(DEPTH);

    entry_t [DEPTH-1:0]    ent_q, ent_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]      fwd_cnt_q, fwd_cnt_d;
    logic [NSRC-1:0]       hit, load_stall;
    logic [NSRC*SELW-1:0]  sel_raw;
    logic                  fwd_any;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_match
        hazard_match #(
            .REG_AW   (REG_AW),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT),
            .SELW     (SELW)
        ) u_match (
            .entries_i       (ent_q),
            .src_addr_i      (src_addr[gi*REG_AW +: REG_AW]),
            .src_used_i      (src_used[gi]),
            .hit_o           (hit[gi]),
            .is_load_stall_o (load_stall[gi]),
            .sel_o           (sel_raw[gi*SELW +: SELW])
        );
    end

    // Combined outputs; flush kills the decode instruction so it never stalls,
    // and outputs are held quiet while reset is asserted.
    always_comb begin
        stall   = (|load_stall) && !flush && !rst;
        fwd_sel = rst ? '0 : sel_raw;
        // A non-stalled hit always carries a nonzero select.
        fwd_any = !rst && (|(hit & ~load_stall));
    end

    // Next table state: shift older, load or bubble entry 0, mask flushed young stages.
    always_comb begin
        ent_d = '0;
        if (issue_valid && !stall && !flush) begin
            ent_d[0].valid    = 1'b1;
            ent_d[0].regwrite = issue_regwrite;
            ent_d[0].memread  = issue_memread;
            ent_d[0].dest     = REG_AW_MAX'(issue_dest);
        end
        for (int k = 1; k < int'(DEPTH); k++) begin
            ent_d[k] = ent_q[k-1];
            if (flush && (k < int'(FLUSH_DEPTH))) begin
                ent_d[k].valid = 1'b0;
            end
        end
    end

    // Saturating counters; clear wins over increment.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (cnt_clear) begin
            stall_cnt_d = '0;
            fwd_cnt_d   = '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (fwd_any && !stall && (fwd_cnt_q != '1)) begin
                fwd_cnt_d = fwd_cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q       <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            ent_q       <= ent_d;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed self-checking bench for hazard_fwd_unit (default geometry, 4-bit counters).
module tb_hazard_fwd_unit;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic        issue_regwrite;
    logic        issue_memread;
    logic [4:0]  issue_dest;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic        flush;
    logic        cnt_clear;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [3:0]  stall_cnt;
    logic [3:0]  fwd_cnt;

    int checks = 0;
    int errors = 0;

    hazard_fwd_unit #(
        .REG_AW      (5),
        .NSRC        (2),
        .DEPTH       (3),
        .LOAD_LAT    (1),
        .FLUSH_DEPTH (1),
        .CNT_W       (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_regwrite (issue_regwrite),
        .issue_memread  (issue_memread),
        .issue_dest     (issue_dest),
        .src_addr       (src_addr),
        .src_used       (src_used),
        .flush          (flush),
        .cnt_clear      (cnt_clear),
        .stall          (stall),
        .fwd_sel        (fwd_sel),
        .stall_cnt      (stall_cnt),
        .fwd_cnt        (fwd_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid    = 1'b0;
        issue_regwrite = 1'b0;
        issue_memread  = 1'b0;
        issue_dest     = '0;
        src_addr       = '0;
        src_used       = '0;
        flush          = 1'b0;
        cnt_clear      = 1'b0;
    endtask

    task automatic issue(input logic [4:0] d, input logic ld);
        issue_valid    = 1'b1;
        issue_regwrite = 1'b1;
        issue_memread  = ld;
        issue_dest     = d;
    endtask

    task automatic use_src(input int i, input logic [4:0] a);
        src_addr[i*5 +: 5] = a;
        src_used[i]        = 1'b1;
    endtask

    // Advance one clock; inputs change and outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            idle();
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_fwd_sel", 32'(fwd_sel), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_fwd_cnt", 32'(fwd_cnt), 32'd0);

        // ALU dependency ages through EX, MEM, WB then drops out.
        idle(); issue(5'd1, 1'b0); #1; tick();
        idle(); use_src(0, 5'd1); #1;
        chk("alu_ex_sel", 32'(fwd_sel[1:0]), 32'd1);
        chk("alu_ex_stall", 32'(stall), 32'd0);
        tick();
        idle(); use_src(0, 5'd1); #1;
        chk("alu_mem_sel", 32'(fwd_sel[1:0]), 32'd2);
        tick();
        idle(); use_src(0, 5'd1); #1;
        chk("alu_wb_sel", 32'(fwd_sel[1:0]), 32'd3);
        tick();
        idle(); use_src(0, 5'd1); #1;
        chk("alu_gone_sel", 32'(fwd_sel[1:0]), 32'd0);
        chk("alu_fwd_cnt", 32'(fwd_cnt), 32'd3);
        tick();

        // Load-use: one stall cycle then MEM forward.
        idle(); cnt_clear = 1'b1; #1; tick();
        idle(); #1;
        chk("clear_fwd_cnt", 32'(fwd_cnt), 32'd0);
        issue(5'd2, 1'b1); #1; tick();
        idle(); issue(5'd5, 1'b0); use_src(1, 5'd2); #1;
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_stall_sel", 32'(fwd_sel[3:2]), 32'd0);
        tick();
        idle(); issue(5'd5, 1'b0); use_src(1, 5'd2); #1;
        chk("lu_after_stall", 32'(stall), 32'd0);
        chk("lu_after_sel", 32'(fwd_sel[3:2]), 32'd2);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        tick();
        drain();

        // Register 0 is never matched.
        idle(); issue(5'd0, 1'b0); #1; tick();
        idle(); use_src(0, 5'd0); use_src(1, 5'd0); #1;
        chk("r0_sel", 32'(fwd_sel), 32'd0);
        tick();
        drain();

        // Two writers of $3: the younger wins.
        idle(); issue(5'd3, 1'b0); #1; tick();
        idle(); issue(5'd3, 1'b0); #1; tick();
        idle(); use_src(0, 5'd3); #1;
        chk("youngest_sel", 32'(fwd_sel[1:0]), 32'd1);
        tick();
        drain();

        // Flush kills the concurrently issued writer.
        idle(); issue(5'd4, 1'b0); flush = 1'b1; #1; tick();
        idle(); use_src(0, 5'd4); #1;
        chk("flush_kill_sel", 32'(fwd_sel[1:0]), 32'd0);
        tick();
        // Flush suppresses a load-use stall; the load itself survives in MEM.
        idle(); issue(5'd6, 1'b1); #1; tick();
        idle(); issue(5'd9, 1'b0); use_src(0, 5'd6); flush = 1'b1; #1;
        chk("flush_stall", 32'(stall), 32'd0);
        chk("flush_lu_sel", 32'(fwd_sel[1:0]), 32'd0);
        tick();
        idle(); use_src(0, 5'd6); #1;
        chk("flush_after_sel", 32'(fwd_sel[1:0]), 32'd2);
        chk("flush_after_stall", 32'(stall), 32'd0);
        tick();
        drain();

        // Counter saturation over 20 forced stalls.
        idle(); cnt_clear = 1'b1; #1; tick();
        for (int i = 0; i < 20; i++) begin
            idle(); issue(5'd7, 1'b1); #1; tick();
            idle(); issue(5'd8, 1'b0); use_src(0, 5'd7); #1; tick();
        end
        idle(); #1;
        chk("sat_stall_cnt", 32'(stall_cnt), 32'd15);
        chk("sat_fwd_cnt", 32'(fwd_cnt), 32'd0);
        tick();
        idle(); issue(5'd7, 1'b1); #1; tick();
        idle(); use_src(0, 5'd7); cnt_clear = 1'b1; #1;
        chk("clr_during_stall", 32'(stall), 32'd1);
        tick();
        idle(); #1;
        chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
        tick();
        drain();

        // Reset with three writers in flight.
        idle(); issue(5'd1, 1'b0); #1; tick();
        idle(); issue(5'd2, 1'b0); #1; tick();
        idle(); issue(5'd3, 1'b0); #1; tick();
        idle(); use_src(0, 5'd3); use_src(1, 5'd1); #1;
        chk("pre_rst_sel", 32'(fwd_sel), 32'hD);
        rst = 1'b1; #1;
        chk("in_rst_sel", 32'(fwd_sel), 32'd0);
        chk("in_rst_stall", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        idle(); use_src(0, 5'd2); use_src(1, 5'd1); #1;
        chk("post_rst_sel", 32'(fwd_sel), 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);
        chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("post_rst_fwd_cnt", 32'(fwd_cnt), 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
